// File: rtl/exe_writeback_lane.sv
// Writeback end of one execute lane: merges single-cycle and multi-cycle results into one
// registered writeback per cycle, parking colliding multi-cycle results in an in-order queue.
module exe_writeback_lane #(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned TAG_W   = 7,
  parameter int unsigned ALID_W  = 7,
  parameter int unsigned Q_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              recoverFlag_i,
  input  logic              sValid_i,
  input  logic              sDestValid_i,
  input  logic [TAG_W-1:0]  sTag_i,
  input  logic [DATA_W-1:0] sData_i,
  input  logic [ALID_W-1:0] sAlId_i,
  input  logic [1:0]        sFlags_i,
  input  logic              mValid_i,
  input  logic              mDestValid_i,
  input  logic [TAG_W-1:0]  mTag_i,
  input  logic [DATA_W-1:0] mData_i,
  input  logic [ALID_W-1:0] mAlId_i,
  input  logic [1:0]        mFlags_i,
  output logic              rfWe_o,
  output logic [TAG_W-1:0]  rfTag_o,
  output logic [DATA_W-1:0] rfData_o,
  output logic              bypValid_o,
  output logic [TAG_W-1:0]  bypTag_o,
  output logic [DATA_W-1:0] bypData_o,
  output logic              alValid_o,
  output logic [ALID_W-1:0] alId_o,
  output logic [1:0]        alFlags_o,
  output logic              mStall_o,
  output logic              overflow_o
);

  localparam int unsigned PTR_W = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(Q_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(Q_DEPTH);
  localparam logic [CNT_W-1:0] STALL_CNT = CNT_W'(Q_DEPTH - 1);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(Q_DEPTH - 1);

  typedef struct packed {
    logic              dest;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
    logic [ALID_W-1:0] alid;
    logic [1:0]        flags;
  } pkt_t;

  pkt_t             q_mem_q [Q_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic              we_q, al_q, stall_q, ovf_q;
  logic [TAG_W-1:0]  tag_q;
  logic [DATA_W-1:0] data_q;
  logic [ALID_W-1:0] alid_q;
  logic [1:0]        flags_q;

  pkt_t s_pkt, m_pkt, sel_pkt;
  logic sel_valid, push, pop, drop, wr_en, stall_d;

  always_comb begin
    s_pkt     = '{dest: sDestValid_i, tag: sTag_i, data: sData_i, alid: sAlId_i, flags: sFlags_i};
    m_pkt     = '{dest: mDestValid_i, tag: mTag_i, data: mData_i, alid: mAlId_i, flags: mFlags_i};
    sel_pkt   = s_pkt;
    sel_valid = 1'b0;
    pop       = 1'b0;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;

    if (sValid_i) begin
      sel_valid = 1'b1;
    end else if (count_q != '0) begin
      sel_pkt   = q_mem_q[rd_ptr_q];
      sel_valid = 1'b1;
      pop       = 1'b1;
    end else if (mValid_i) begin
      sel_pkt   = m_pkt;
      sel_valid = 1'b1;
    end

    // M goes to the queue whenever it is not taken directly, keeping M results in order.
    push  = mValid_i && (sValid_i || (count_q != '0));
    drop  = push && !pop && (count_q == FULL_CNT);
    wr_en = push && !drop;

    if (pop)   rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
    if (wr_en) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
    if (wr_en && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !wr_en) count_d = count_q - CNT_W'(1);

    if (recoverFlag_i) begin
      sel_valid = 1'b0;
      wr_en     = 1'b0;
      drop      = 1'b0;
      rd_ptr_d  = '0;
      wr_ptr_d  = '0;
      count_d   = '0;
    end

    stall_d = (count_d >= STALL_CNT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < Q_DEPTH; i++) q_mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      we_q     <= 1'b0;
      al_q     <= 1'b0;
      stall_q  <= 1'b0;
      ovf_q    <= 1'b0;
      tag_q    <= '0;
      data_q   <= '0;
      alid_q   <= '0;
      flags_q  <= '0;
    end else begin
      if (wr_en) q_mem_q[wr_ptr_q] <= m_pkt;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      we_q     <= sel_valid && sel_pkt.dest;
      al_q     <= sel_valid;
      stall_q  <= stall_d;
      if (drop) ovf_q <= 1'b1;
      if (sel_valid) begin
        tag_q   <= sel_pkt.tag;
        data_q  <= sel_pkt.data;
        alid_q  <= sel_pkt.alid;
        flags_q <= sel_pkt.flags;
      end
    end
  end

  assign rfWe_o     = we_q;
  assign rfTag_o    = tag_q;
  assign rfData_o   = data_q;
  assign bypValid_o = we_q;
  assign bypTag_o   = tag_q;
  assign bypData_o  = data_q;
  assign alValid_o  = al_q;
  assign alId_o     = alid_q;
  assign alFlags_o  = flags_q;
  assign mStall_o   = stall_q;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_exe_writeback_lane.sv
// Directed bench for exe_writeback_lane: each task drives one scenario and checks inline.
module tb_exe_writeback_lane;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned TAG_W  = 7;
  localparam int unsigned ALID_W = 7;

  logic              clk = 1'b0;
  logic              reset;
  logic              recoverFlag_i;
  logic              sValid_i, sDestValid_i, mValid_i, mDestValid_i;
  logic [TAG_W-1:0]  sTag_i, mTag_i;
  logic [DATA_W-1:0] sData_i, mData_i;
  logic [ALID_W-1:0] sAlId_i, mAlId_i;
  logic [1:0]        sFlags_i, mFlags_i;
  logic              rfWe_o, bypValid_o, alValid_o, mStall_o, overflow_o;
  logic [TAG_W-1:0]  rfTag_o, bypTag_o;
  logic [DATA_W-1:0] rfData_o, bypData_o;
  logic [ALID_W-1:0] alId_o;
  logic [1:0]        alFlags_o;

  int tests = 0;
  int fails = 0;

  exe_writeback_lane #(.DATA_W(DATA_W), .TAG_W(TAG_W), .ALID_W(ALID_W), .Q_DEPTH(2)) dut (
    .clk(clk), .reset(reset), .recoverFlag_i(recoverFlag_i),
    .sValid_i(sValid_i), .sDestValid_i(sDestValid_i), .sTag_i(sTag_i), .sData_i(sData_i),
    .sAlId_i(sAlId_i), .sFlags_i(sFlags_i),
    .mValid_i(mValid_i), .mDestValid_i(mDestValid_i), .mTag_i(mTag_i), .mData_i(mData_i),
    .mAlId_i(mAlId_i), .mFlags_i(mFlags_i),
    .rfWe_o(rfWe_o), .rfTag_o(rfTag_o), .rfData_o(rfData_o),
    .bypValid_o(bypValid_o), .bypTag_o(bypTag_o), .bypData_o(bypData_o),
    .alValid_o(alValid_o), .alId_o(alId_o), .alFlags_o(alFlags_o),
    .mStall_o(mStall_o), .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    recoverFlag_i = 1'b0;
    sValid_i = 1'b0; sDestValid_i = 1'b0; sTag_i = '0; sData_i = '0; sAlId_i = '0; sFlags_i = '0;
    mValid_i = 1'b0; mDestValid_i = 1'b0; mTag_i = '0; mData_i = '0; mAlId_i = '0; mFlags_i = '0;
  endtask

  task automatic drive_s(input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] data,
                         input logic [ALID_W-1:0] alid);
    sValid_i = 1'b1; sDestValid_i = 1'b1; sTag_i = tag; sData_i = data; sAlId_i = alid; sFlags_i = 2'b00;
  endtask

  task automatic drive_m(input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] data,
                         input logic [ALID_W-1:0] alid);
    mValid_i = 1'b1; mDestValid_i = 1'b1; mTag_i = tag; mData_i = data; mAlId_i = alid; mFlags_i = 2'b00;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    tests++; if ({rfWe_o, bypValid_o, alValid_o} !== 3'b000) begin fails++;
      $display("FAIL reset_valids got %b exp 000", {rfWe_o, bypValid_o, alValid_o}); end
    tests++; if ({rfTag_o, rfData_o, alId_o, alFlags_o} !== '0) begin fails++;
      $display("FAIL reset_fields got tag %0h data %0h id %0h fl %b exp 0", rfTag_o, rfData_o, alId_o, alFlags_o); end
    tests++; if ({mStall_o, overflow_o} !== 2'b00) begin fails++;
      $display("FAIL reset_stall_ovf got %b exp 00", {mStall_o, overflow_o}); end
    @(negedge clk);
    reset = 1'b0;
    step();
  endtask

  task automatic test_s_only();
    drive_s(7'd5, 64'hAB, 7'd3);
    step();
    idle_inputs();
    tests++; if ({rfWe_o, bypValid_o, alValid_o} !== 3'b111) begin fails++;
      $display("FAIL s_only_valids got %b exp 111", {rfWe_o, bypValid_o, alValid_o}); end
    tests++; if (rfTag_o !== 7'd5 || bypTag_o !== 7'd5) begin fails++;
      $display("FAIL s_only_tag got %0d/%0d exp 5", rfTag_o, bypTag_o); end
    tests++; if (rfData_o !== 64'hAB || bypData_o !== 64'hAB) begin fails++;
      $display("FAIL s_only_data got %0h/%0h exp ab", rfData_o, bypData_o); end
    tests++; if (alId_o !== 7'd3) begin fails++;
      $display("FAIL s_only_alid got %0d exp 3", alId_o); end
    step();
    tests++; if ({rfWe_o, bypValid_o, alValid_o} !== 3'b000) begin fails++;
      $display("FAIL s_only_idle got %b exp 000", {rfWe_o, bypValid_o, alValid_o}); end
  endtask

  task automatic test_collision();
    drive_s(7'd1, 64'h11, 7'd10);
    drive_m(7'd2, 64'h22, 7'd11);
    step();
    idle_inputs();
    tests++; if (rfWe_o !== 1'b1 || rfTag_o !== 7'd1 || rfData_o !== 64'h11) begin fails++;
      $display("FAIL coll_first got we %b tag %0d data %0h exp 1 1 11", rfWe_o, rfTag_o, rfData_o); end
    tests++; if (mStall_o !== 1'b1) begin fails++;
      $display("FAIL coll_stall got %b exp 1", mStall_o); end
    step();
    tests++; if (rfWe_o !== 1'b1 || rfTag_o !== 7'd2 || rfData_o !== 64'h22 || alId_o !== 7'd11) begin fails++;
      $display("FAIL coll_second got we %b tag %0d data %0h id %0d exp 1 2 22 11", rfWe_o, rfTag_o, rfData_o, alId_o); end
    tests++; if (mStall_o !== 1'b0) begin fails++;
      $display("FAIL coll_stall_clear got %b exp 0", mStall_o); end
    step();
    tests++; if (alValid_o !== 1'b0) begin fails++;
      $display("FAIL coll_idle got %b exp 0", alValid_o); end
  endtask

  task automatic test_order();
    drive_s(7'd10, 64'h100, 7'd1);
    drive_m(7'd2, 64'h200, 7'd2);
    step();
    idle_inputs();
    drive_m(7'd3, 64'h300, 7'd3);
    tests++; if (rfTag_o !== 7'd10 || rfWe_o !== 1'b1) begin fails++;
      $display("FAIL order_s got tag %0d we %b exp 10 1", rfTag_o, rfWe_o); end
    step();
    idle_inputs();
    tests++; if (rfTag_o !== 7'd2 || rfWe_o !== 1'b1) begin fails++;
      $display("FAIL order_m1 got tag %0d we %b exp 2 1", rfTag_o, rfWe_o); end
    tests++; if (mStall_o !== 1'b1) begin fails++;
      $display("FAIL order_stall got %b exp 1", mStall_o); end
    step();
    tests++; if (rfTag_o !== 7'd3 || rfData_o !== 64'h300 || rfWe_o !== 1'b1) begin fails++;
      $display("FAIL order_m2 got tag %0d data %0h we %b exp 3 300 1", rfTag_o, rfData_o, rfWe_o); end
    step();
    tests++; if (alValid_o !== 1'b0 || mStall_o !== 1'b0) begin fails++;
      $display("FAIL order_idle got al %b stall %b exp 0 0", alValid_o, mStall_o); end
  endtask

  task automatic test_no_dest();
    drive_s(7'd9, 64'h99, 7'd6);
    sDestValid_i = 1'b0;
    sFlags_i = 2'b01;
    step();
    idle_inputs();
    tests++; if (alValid_o !== 1'b1 || alFlags_o !== 2'b01 || alId_o !== 7'd6) begin fails++;
      $display("FAIL nodest_al got v %b fl %b id %0d exp 1 01 6", alValid_o, alFlags_o, alId_o); end
    tests++; if (rfWe_o !== 1'b0 || bypValid_o !== 1'b0) begin fails++;
      $display("FAIL nodest_we got we %b byp %b exp 0 0", rfWe_o, bypValid_o); end
    step();
  endtask

  task automatic test_recovery();
    drive_s(7'd40, 64'h40, 7'd1);
    drive_m(7'd20, 64'h20, 7'd2);
    step();
    drive_s(7'd41, 64'h41, 7'd3);
    drive_m(7'd21, 64'h21, 7'd4);
    step();
    drive_s(7'd42, 64'h42, 7'd5);
    drive_m(7'd22, 64'h22, 7'd6);
    recoverFlag_i = 1'b1;
    tests++; if (mStall_o !== 1'b1) begin fails++;
      $display("FAIL rec_prefill_stall got %b exp 1", mStall_o); end
    step();
    idle_inputs();
    drive_s(7'd30, 64'h30, 7'd7);
    tests++; if ({rfWe_o, bypValid_o, alValid_o} !== 3'b000) begin fails++;
      $display("FAIL rec_valids got %b exp 000", {rfWe_o, bypValid_o, alValid_o}); end
    tests++; if (mStall_o !== 1'b0 || overflow_o !== 1'b0) begin fails++;
      $display("FAIL rec_stall_ovf got %b %b exp 0 0", mStall_o, overflow_o); end
    step();
    idle_inputs();
    tests++; if (rfWe_o !== 1'b1 || rfTag_o !== 7'd30) begin fails++;
      $display("FAIL rec_new_s got we %b tag %0d exp 1 30", rfWe_o, rfTag_o); end
    step();
    tests++; if (alValid_o !== 1'b0) begin fails++;
      $display("FAIL rec_queue_empty got %b exp 0", alValid_o); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 3; i++) begin
      drive_s(7'(40 + i), 64'(40 + i), 7'(i));
      drive_m(7'(50 + i), 64'(50 + i), 7'(20 + i));
      step();
      tests++; if (rfTag_o !== 7'(40 + i) || overflow_o !== (i == 2)) begin fails++;
        $display("FAIL ovf_cycle%0d got tag %0d ovf %b exp %0d %b", i, rfTag_o, overflow_o, 40 + i, i == 2); end
    end
    idle_inputs();
    drive_s(7'd43, 64'd43, 7'd3);
    step();
    idle_inputs();
    tests++; if (rfTag_o !== 7'd43 || overflow_o !== 1'b1) begin fails++;
      $display("FAIL ovf_sticky got tag %0d ovf %b exp 43 1", rfTag_o, overflow_o); end
    step();
    tests++; if (rfTag_o !== 7'd50 || rfWe_o !== 1'b1) begin fails++;
      $display("FAIL ovf_drain0 got tag %0d we %b exp 50 1", rfTag_o, rfWe_o); end
    step();
    tests++; if (rfTag_o !== 7'd51 || rfWe_o !== 1'b1) begin fails++;
      $display("FAIL ovf_drain1 got tag %0d we %b exp 51 1", rfTag_o, rfWe_o); end
    step();
    tests++; if (alValid_o !== 1'b0 || overflow_o !== 1'b1) begin fails++;
      $display("FAIL ovf_dropped got al %b ovf %b exp 0 1", alValid_o, overflow_o); end
  endtask

  task automatic test_async_reset();
    drive_s(7'd60, 64'h60, 7'd1);
    drive_m(7'd61, 64'h61, 7'd2);
    step();
    idle_inputs();
    #2;
    reset = 1'b1;
    #1;
    tests++; if ({rfWe_o, alValid_o, mStall_o, overflow_o} !== 4'b0000) begin fails++;
      $display("FAIL areset_clear got %b exp 0000", {rfWe_o, alValid_o, mStall_o, overflow_o}); end
    @(negedge clk);
    reset = 1'b0;
    step();
    tests++; if (alValid_o !== 1'b0 || rfWe_o !== 1'b0) begin fails++;
      $display("FAIL areset_queue got al %b we %b exp 0 0", alValid_o, rfWe_o); end
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    test_reset();
    test_s_only();
    test_collision();
    test_order();
    test_no_dest();
    test_recovery();
    test_overflow();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
